cmd_response_stp: RTL and testbench

Serial-to-parallel receiver for SD command-line responses. It sits directly downstream of the card's CMD pad and upstream of the command physical controller. When enabled, it waits for a start bit and shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response MSB-first. It then checks CRC7 and framing, and presents the frame on pad_response with a level reception_complete back to the controller.

---
 rtl/sd_cmd_pkg.sv | 19 +
 rtl/crc7_serial.sv | 37 +++
 rtl/cmd_response_stp.sv | 158 +++++++++++++++
 tb/tb_cmd_response_stp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared constants for the SD command-line receive path: frame lengths,
// CRC7 polynomial and the receiver state encoding.
package sd_cmd_pkg;

  localparam int LONG_BITS  = 136;
  localparam int SHORT_BITS = 48;

  // x^7 + x^3 + 1 with the x^7 term implied
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WAIT_START = 4'd1,
    ST_RECEIVE    = 4'd2,
    ST_CHECK      = 4'd3,
    ST_DONE       = 4'd4
  } stp_state_e;

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 generator; one message bit per sd_clock while enable is high.
module crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic       sd_clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc_out
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic       feedback;

  always_comb begin
    feedback = bit_in ^ crc_q[6];
    crc_d    = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/cmd_response_stp.sv
// SD CMD-line response receiver: waits for a start bit, shifts in a 48- or
// 136-bit frame MSB-first, then checks CRC7 and framing bits.
module cmd_response_stp
  import sd_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                 sd_clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 long_resp,
  input  logic                 check_crc,
  input  logic                 cmd_in,
  output logic [LONG_BITS-1:0] pad_response,
  output logic                 reception_complete,
  output logic                 crc_error,
  output logic                 frame_error,
  output logic                 timeout_error
);

  stp_state_e           state_q, state_d;
  logic                 long_q, long_d;
  logic                 chk_q, chk_d;
  logic [LONG_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     timeout_cnt_q, timeout_cnt_d;
  logic                 crc_err_q, crc_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [CNT_W-1:0]     last_idx;
  logic [CNT_W-1:0]     tx_idx;
  logic [CNT_W-1:0]     crc_lo;
  logic [CNT_W-1:0]     crc_hi;
  logic                 crc_clear;
  logic                 crc_en;
  logic [6:0]           crc_value;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // bit_cnt holds how many bits are already in; the bit being captured has
  // frame index last_idx - bit_cnt, so the CRC window maps to a count range.
  always_comb begin
    last_idx = long_q ? CNT_W'(LONG_BITS - 1) : CNT_W'(SHORT_BITS - 1);
    tx_idx   = last_idx - 1'b1;
    crc_lo   = long_q ? CNT_W'(8) : '0;
    crc_hi   = last_idx - CNT_W'(8);
  end

  always_comb begin
    state_d       = state_q;
    long_d        = long_q;
    chk_d         = chk_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    crc_err_d     = crc_err_q;
    frame_err_d   = frame_err_q;
    timeout_err_d = timeout_err_q;
    crc_clear     = 1'b0;
    crc_en        = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d       = ST_WAIT_START;
          long_d        = long_resp;
          chk_d         = check_crc;
          shift_d       = '0;
          bit_cnt_d     = '0;
          timeout_cnt_d = '0;
          crc_err_d     = 1'b0;
          frame_err_d   = 1'b0;
          timeout_err_d = 1'b0;
          crc_clear     = 1'b1;
        end
        ST_WAIT_START: begin
          if (!cmd_in) begin
            shift_d   = {shift_q[LONG_BITS-2:0], cmd_in};
            bit_cnt_d = CNT_W'(1);
            crc_en    = !long_q;
            state_d   = ST_RECEIVE;
          end else if (timeout_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err_d = 1'b1;
            state_d       = ST_DONE;
          end else begin
            timeout_cnt_d = sat_inc(timeout_cnt_q);
          end
        end
        ST_RECEIVE: begin
          shift_d   = {shift_q[LONG_BITS-2:0], cmd_in};
          bit_cnt_d = sat_inc(bit_cnt_q);
          crc_en    = (bit_cnt_q >= crc_lo) && (bit_cnt_q <= crc_hi);
          if (bit_cnt_q == last_idx) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          frame_err_d = shift_q[tx_idx] | ~shift_q[0];
          crc_err_d   = chk_q & (crc_value != shift_q[7:1]);
          state_d     = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      long_q        <= 1'b0;
      chk_q         <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      timeout_cnt_q <= '0;
      crc_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      long_q        <= long_d;
      chk_q         <= chk_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      crc_err_q     <= crc_err_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  crc7_serial u_crc7 (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear    (crc_clear),
    .enable   (crc_en),
    .bit_in   (cmd_in),
    .crc_out  (crc_value)
  );

  // Gated with enable so the controller sees completion fall as soon as it lets go.
  assign reception_complete = (state_q == ST_DONE) & enable;
  assign pad_response       = shift_q;
  assign crc_error          = crc_err_q;
  assign frame_error        = frame_err_q;
  assign timeout_error      = timeout_err_q;

endmodule

// File: tb/tb_cmd_response_stp.sv
// Directed bench for cmd_response_stp: short/long frames, CRC and framing
// faults, start-bit timeout, enable abort and mid-frame reset.
module tb_cmd_response_stp;

  logic         sd_clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         long_resp;
  logic         check_crc;
  logic         cmd_in;
  logic [135:0] pad_response;
  logic         reception_complete;
  logic         crc_error;
  logic         frame_error;
  logic         timeout_error;

  int checks = 0;
  int errors = 0;

  logic [135:0] frame_a, frame_b, frame_c, frame_d, frame_e, model_in;
  logic [127:0] rnd;

  cmd_response_stp dut (
    .sd_clock           (sd_clock),
    .reset              (reset),
    .enable             (enable),
    .long_resp          (long_resp),
    .check_crc          (check_crc),
    .cmd_in             (cmd_in),
    .pad_response       (pad_response),
    .reception_complete (reception_complete),
    .crc_error          (crc_error),
    .frame_error        (frame_error),
    .timeout_error      (timeout_error)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic tick;
    @(posedge sd_clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [135:0] observed, input logic [135:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drive 'count' bits of an nbits-long frame, MSB first, one per clock.
  task automatic applyStimulus(input int nbits, input logic [135:0] frame, input int count);
    for (int i = 0; i < count; i++) begin
      cmd_in = frame[nbits-1-i];
      tick();
    end
    cmd_in = 1'b1;
  endtask

  // Reference CRC7 (x^7+x^3+1) over frame bits hi down to lo.
  function automatic logic [6:0] crcModel(input logic [135:0] f, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = hi; i >= lo; i--) begin
      fb = f[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    long_resp = 1'b0;
    check_crc = 1'b0;
    cmd_in    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset_pad", pad_response, '0);
    checkFlag("reset_complete", reception_complete, 1'b0);
    checkFlag("reset_crc_err", crc_error, 1'b0);
    checkFlag("reset_frame_err", frame_error, 1'b0);
    checkFlag("reset_timeout_err", timeout_error, 1'b0);

    // Short R1 with all-zero payload; mode inputs wiggled after latch.
    $display("[TB] short R1 valid CRC");
    frame_a   = 136'h000000000001;
    long_resp = 1'b0;
    check_crc = 1'b1;
    enable    = 1'b1;
    tick();
    long_resp = 1'b1;
    check_crc = 1'b0;
    repeat (5) tick();
    applyStimulus(48, frame_a, 48);
    checkFlag("r1_not_yet_complete", reception_complete, 1'b0);
    tick();
    checkFlag("r1_complete", reception_complete, 1'b1);
    checkOutput("r1_pad", pad_response, frame_a);
    checkFlag("r1_crc_err", crc_error, 1'b0);
    checkFlag("r1_frame_err", frame_error, 1'b0);
    checkFlag("r1_timeout_err", timeout_error, 1'b0);
    enable = 1'b0;
    #1;
    checkFlag("r1_drop_same_cycle", reception_complete, 1'b0);
    tick();
    checkOutput("r1_pad_retained", pad_response, frame_a);

    // Model sanity: CMD0 body has the well-known CRC7 0x4A.
    model_in = {88'b0, 40'h4000000000, 8'h00};
    checkOutput("model_cmd0_crc", 136'(crcModel(model_in, 47, 8)), 136'(7'h4A));

    // Corrupted bit 20; cmd_in low on the enable edge must not count as start.
    $display("[TB] short R1 CRC corruption");
    frame_b   = frame_a ^ (136'd1 << 20);
    long_resp = 1'b0;
    check_crc = 1'b1;
    cmd_in    = 1'b0;
    enable    = 1'b1;
    tick();
    cmd_in = 1'b1;
    tick();
    applyStimulus(48, frame_b, 48);
    tick();
    checkFlag("crc_bad_complete", reception_complete, 1'b1);
    checkFlag("crc_bad_crc_err", crc_error, 1'b1);
    checkFlag("crc_bad_frame_err", frame_error, 1'b0);
    checkOutput("crc_bad_pad", pad_response, frame_b);
    enable = 1'b0;
    tick();

    // Long R2 with random CID and model-computed CRC.
    $display("[TB] long R2");
    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    frame_c = {2'b00, 6'h3F, rnd[119:0], 7'h00, 1'b1};
    frame_c[7:1] = crcModel(frame_c, 127, 8);
    long_resp = 1'b1;
    check_crc = 1'b1;
    enable    = 1'b1;
    tick();
    long_resp = 1'b0;
    tick();
    applyStimulus(136, frame_c, 136);
    checkFlag("r2_not_yet_complete", reception_complete, 1'b0);
    tick();
    checkFlag("r2_complete", reception_complete, 1'b1);
    checkOutput("r2_pad", pad_response, frame_c);
    checkFlag("r2_crc_err", crc_error, 1'b0);
    checkFlag("r2_frame_err", frame_error, 1'b0);
    enable = 1'b0;
    tick();

    // No start bit: completion exactly 64 clocks after the enable edge.
    $display("[TB] start-bit timeout");
    cmd_in = 1'b1;
    enable = 1'b1;
    tick();
    repeat (63) tick();
    checkFlag("timeout_not_yet", reception_complete, 1'b0);
    tick();
    checkFlag("timeout_complete", reception_complete, 1'b1);
    checkFlag("timeout_flag", timeout_error, 1'b1);
    checkOutput("timeout_pad_zero", pad_response, '0);
    enable = 1'b0;
    tick();
    checkFlag("timeout_flag_held", timeout_error, 1'b1);

    // R3 style: CRC compare off, bad end bit.
    $display("[TB] R3 framing error");
    frame_d   = {88'b0, 2'b00, 6'h3F, 32'h12345678, 7'h7F, 1'b0};
    long_resp = 1'b0;
    check_crc = 1'b0;
    enable    = 1'b1;
    tick();
    applyStimulus(48, frame_d, 48);
    tick();
    checkFlag("r3_complete", reception_complete, 1'b1);
    checkFlag("r3_frame_err", frame_error, 1'b1);
    checkFlag("r3_crc_err", crc_error, 1'b0);
    checkFlag("r3_timeout_cleared", timeout_error, 1'b0);
    checkOutput("r3_pad", pad_response, frame_d);
    enable = 1'b0;
    tick();

    // Abort after 30 bits, then a full frame must still be received cleanly.
    $display("[TB] enable abort");
    frame_e = {88'b0, 40'h0A12345678, 7'h00, 1'b1};
    frame_e[7:1] = crcModel(frame_e, 47, 8);
    check_crc = 1'b1;
    enable    = 1'b1;
    tick();
    applyStimulus(48, frame_e, 30);
    enable = 1'b0;
    tick();
    checkFlag("abort_no_complete", reception_complete, 1'b0);
    repeat (20) tick();
    enable = 1'b1;
    #1;
    checkFlag("abort_idle_on_reenable", reception_complete, 1'b0);
    tick();
    tick();
    applyStimulus(48, frame_e, 48);
    tick();
    checkFlag("after_abort_complete", reception_complete, 1'b1);
    checkOutput("after_abort_pad", pad_response, frame_e);
    checkFlag("after_abort_crc_err", crc_error, 1'b0);
    checkFlag("after_abort_frame_err", frame_error, 1'b0);

    // Reset in the middle of a frame wins over enable.
    $display("[TB] mid-frame reset");
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    applyStimulus(48, frame_e, 20);
    reset = 1'b1;
    tick();
    checkOutput("midreset_pad", pad_response, '0);
    checkFlag("midreset_complete", reception_complete, 1'b0);
    checkFlag("midreset_crc_err", crc_error, 1'b0);
    checkFlag("midreset_frame_err", frame_error, 1'b0);
    checkFlag("midreset_timeout_err", timeout_error, 1'b0);
    reset  = 1'b0;
    enable = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
